// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       AdrSrc;
    logic       Branch;
    logic       Csr;
    logic [1:0] ALUSrc_A;
    logic [1:0] ALUSrc_B;
    logic [1:0] ALUop;
    logic [1:0] ResultSrc;
    logic [2:0] ImmSrc;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc, Branch, Csr,
        output ALUSrc_A, ALUSrc_B, ALUop, ResultSrc, ImmSrc, fault, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc, Branch, Csr,
        input  ALUSrc_A, ALUSrc_B, ALUop, ResultSrc, ImmSrc, fault, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: one state per cycle, memory states stall on mem_ready.
// Bounded memory waits trip a sticky fault; only reset leaves FAULT.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC_R = 4'd6,  EXEC_I = 4'd7,
        ALUWB  = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR   = 4'd11,
        UPPER  = 4'd12, CSR    = 4'd13, FAULT  = 4'd15
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q;
    logic          sub_q;     // opcode[5] from DECODE: sw vs lw, lui vs auipc
    logic          fault_q;
    logic          wait_state, timed_out;

    assign wait_state = state_q inside {FETCH, MEMRD, MEMWR};
    assign timed_out  = wait_state && !bus.mem_ready && (wait_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
            sub_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_q <= '0;
            else if (wait_state && !bus.mem_ready)
                wait_q <= wait_q + 1'b1;
            if (state_q == DECODE)
                sub_q <= bus.opcode[5];
            if (state_d == FAULT)
                fault_q <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.PCWrite   = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.Branch    = 1'b0;
        bus.Csr       = 1'b0;
        bus.ALUSrc_A  = 2'b00;
        bus.ALUSrc_B  = 2'b00;
        bus.ALUop     = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.ImmSrc    = 3'b000;
        case (state_q)
            FETCH: begin
                bus.MemRead   = 1'b1;
                bus.ALUSrc_B  = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                if (bus.mem_ready)  state_d = DECODE;
                else if (timed_out) state_d = FAULT;
            end
            DECODE: begin
                bus.ALUSrc_A = 2'b01;
                bus.ALUSrc_B = 2'b01;
                case (bus.opcode)
                    7'b0000011: state_d = MEMADR;
                    7'b0100011: begin state_d = MEMADR; bus.ImmSrc = 3'b001; end
                    7'b0110011: state_d = EXEC_R;
                    7'b0010011: state_d = EXEC_I;
                    7'b1100011: begin state_d = BRANCH; bus.ImmSrc = 3'b010; end
                    7'b1101111: begin state_d = JAL;    bus.ImmSrc = 3'b011; end
                    7'b1100111: state_d = JALR;
                    7'b0110111,
                    7'b0010111: begin state_d = UPPER;  bus.ImmSrc = 3'b100; end
                    7'b1110011: state_d = CSR;
                    default:    state_d = FAULT;
                endcase
            end
            MEMADR: begin
                bus.ALUSrc_A = 2'b10;
                bus.ALUSrc_B = 2'b01;
                state_d      = sub_q ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.AdrSrc  = 1'b1;
                if (bus.mem_ready)  state_d = MEMWB;
                else if (timed_out) state_d = FAULT;
            end
            MEMWB: begin
                bus.RegWrite  = 1'b1;
                bus.ResultSrc = 2'b01;
                state_d       = FETCH;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
                if (bus.mem_ready)  state_d = FETCH;
                else if (timed_out) state_d = FAULT;
            end
            EXEC_R: begin
                bus.ALUSrc_A = 2'b10;
                bus.ALUop    = 2'b10;
                state_d      = ALUWB;
            end
            EXEC_I: begin
                bus.ALUSrc_A = 2'b10;
                bus.ALUSrc_B = 2'b01;
                bus.ALUop    = 2'b10;
                state_d      = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                bus.Branch   = 1'b1;
                bus.ALUSrc_A = 2'b10;
                bus.ALUop    = 2'b01;
                state_d      = FETCH;
            end
            JAL: begin
                bus.RegWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                state_d      = FETCH;
            end
            JALR: begin
                bus.RegWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                bus.ALUSrc_A = 2'b10;
                bus.ALUSrc_B = 2'b01;
                state_d      = FETCH;
            end
            UPPER: begin
                bus.ALUSrc_A = sub_q ? 2'b11 : 2'b01;
                bus.ALUSrc_B = 2'b01;
                state_d      = ALUWB;
            end
            CSR: begin
                bus.Csr       = 1'b1;
                bus.RegWrite  = 1'b1;
                bus.ResultSrc = 2'b11;
                state_d       = FETCH;
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    assign bus.fault = fault_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a cycle-level reference model and per-cycle compare.
module tb_multicycle_ctrl;
    localparam int TO = 16;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_SYS = 7'b1110011, OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: abstract state number, cycles spent waiting, opcode seen in DECODE
    int         m_state = 0;
    int         m_wait  = 0;
    logic [6:0] m_op    = 7'b0;

    function automatic int model_next(int st, logic [6:0] op, logic [6:0] lop, logic mr, int w);
        case (st)
            0, 3, 5: begin
                if (mr) return (st == 0) ? 1 : (st == 3) ? 4 : 0;
                if (w + 1 >= TO) return 15;
                return st;
            end
            1: begin
                if (op == OP_LW || op == OP_SW) return 2;
                if (op == OP_R) return 6;
                if (op == OP_I) return 7;
                if (op == OP_BR) return 9;
                if (op == OP_JAL) return 10;
                if (op == OP_JALR) return 11;
                if (op == OP_LUI || op == OP_AUIPC) return 12;
                if (op == OP_SYS) return 13;
                return 15;
            end
            2: return (lop == OP_SW) ? 5 : 3;
            6, 7, 12: return 8;
            4, 8, 9, 10, 11, 13: return 0;
            default: return 15;
        endcase
    endfunction

    function automatic logic [19:0] model_out(int st, logic [6:0] op, logic [6:0] lop, logic mr);
        logic pcw, irw, mrd, mwr, rw, adr, br, csr, flt;
        logic [1:0] a, b, alu, rs;
        logic [2:0] imm;
        {pcw, irw, mrd, mwr, rw, adr, br, csr, flt} = '0;
        {a, b, alu, rs, imm} = '0;
        case (st)
            0: begin mrd = 1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            1: begin
                a = 2'b01; b = 2'b01;
                imm = (op == OP_SW) ? 3'd1 : (op == OP_BR) ? 3'd2 : (op == OP_JAL) ? 3'd3 :
                      (op == OP_LUI || op == OP_AUIPC) ? 3'd4 : 3'd0;
            end
            2: begin a = 2'b10; b = 2'b01; end
            3: begin mrd = 1; adr = 1; end
            4: begin rw = 1; rs = 2'b01; end
            5: begin mwr = 1; adr = 1; end
            6: begin a = 2'b10; alu = 2'b10; end
            7: begin a = 2'b10; b = 2'b01; alu = 2'b10; end
            8: rw = 1;
            9: begin br = 1; a = 2'b10; alu = 2'b01; end
            10: begin rw = 1; pcw = 1; end
            11: begin rw = 1; pcw = 1; a = 2'b10; b = 2'b01; end
            12: begin a = (lop == OP_LUI) ? 2'b11 : 2'b01; b = 2'b01; end
            13: begin csr = 1; rw = 1; rs = 2'b11; end
            default: flt = 1;
        endcase
        return {pcw, irw, mrd, mwr, rw, adr, br, csr, a, b, alu, rs, imm, flt};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0;
            m_wait  <= 0;
        end else begin
            int nx;
            nx = model_next(m_state, bus.opcode, m_op, bus.mem_ready, m_wait);
            if (m_state == 1) m_op <= bus.opcode;
            if (nx != m_state)                                       m_wait <= 0;
            else if (m_state inside {0, 3, 5} && !bus.mem_ready)     m_wait <= m_wait + 1;
            m_state <= nx;
        end
    end

    always @(negedge clk) begin
        logic [19:0] dut_vec;
        dut_vec = {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite,
                   bus.AdrSrc, bus.Branch, bus.Csr, bus.ALUSrc_A, bus.ALUSrc_B, bus.ALUop,
                   bus.ResultSrc, bus.ImmSrc, bus.fault};
        check("cmp_state", 32'(bus.state), m_state);
        check("cmp_outputs", 32'(dut_vec), 32'(model_out(m_state, bus.opcode, m_op, bus.mem_ready)));
    end

    // Check the current state, then apply mem_ready for this cycle
    task automatic at(input string nm, input int exp, input logic mr);
        check(nm, 32'(bus.state), exp);
        bus.mem_ready = mr;
        #1;
    endtask

    task automatic step(input string nm, input int exp, input logic mr);
        @(posedge clk);
        #2;
        at(nm, exp, mr);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        #1;
        check({nm, "_state"}, 32'(bus.state), 0);
        check({nm, "_fault"}, 32'(bus.fault), 0);
        check({nm, "_memread"}, 32'(bus.MemRead), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    logic [6:0] tbl_op [7] = '{OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS, OP_I};
    int         tbl_s3 [7] = '{9, 10, 11, 12, 12, 13, 7};

    initial begin
        bus.opcode    = OP_R;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_state", 32'(bus.state), 0);
        check("rst_fault", 32'(bus.fault), 0);
        reset = 1'b0;

        // R-type with memory always ready
        at("r_fetch", 0, 1);
        check("r_fetch_irw", 32'(bus.IRWrite), 1);
        step("r_decode", 1, 1);
        step("r_exec", 6, 1);
        check("r_exec_rw", 32'(bus.RegWrite), 0);
        step("r_aluwb", 8, 1);
        check("r_aluwb_rw", 32'(bus.RegWrite), 1);
        step("r_fetch2", 0, 1);

        // Load with three stall cycles in MEMRD
        bus.opcode = OP_LW;
        step("lw_decode", 1, 1);
        step("lw_memadr", 2, 0);
        step("lw_memrd1", 3, 0);
        check("lw_memread", 32'(bus.MemRead), 1);
        check("lw_adrsrc", 32'(bus.AdrSrc), 1);
        step("lw_memrd2", 3, 0);
        step("lw_memrd3", 3, 0);
        step("lw_memrd4", 3, 1);
        step("lw_memwb", 4, 1);
        check("lw_memwb_rw", 32'(bus.RegWrite), 1);
        check("lw_memwb_rs", 32'(bus.ResultSrc), 1);
        step("lw_fetch", 0, 1);

        // Store
        bus.opcode = OP_SW;
        step("sw_decode", 1, 1);
        check("sw_imm", 32'(bus.ImmSrc), 1);
        step("sw_memadr", 2, 1);
        check("sw_adr_mw", 32'(bus.MemWrite), 0);
        step("sw_memwr", 5, 1);
        check("sw_memwr_mw", 32'(bus.MemWrite), 1);
        step("sw_fetch", 0, 1);

        // Remaining opcode classes
        for (int i = 0; i < 7; i++) begin
            bus.opcode = tbl_op[i];
            step("tbl_decode", 1, 1);
            step("tbl_exec", tbl_s3[i], 1);
            if (tbl_s3[i] == 12 || tbl_s3[i] == 7) step("tbl_aluwb", 8, 1);
            step("tbl_fetch", 0, 1);
        end

        // Illegal opcode
        bus.opcode = OP_BAD;
        step("ill_decode", 1, 1);
        step("ill_fault", 15, 1);
        check("ill_fault_flag", 32'(bus.fault), 1);
        step("ill_hold1", 15, 0);
        step("ill_hold2", 15, 1);
        check("ill_fault_held", 32'(bus.fault), 1);
        do_reset("ill_rst");

        // Fetch timeout: 16 stalled cycles
        bus.opcode = OP_R;
        at("to_f0", 0, 0);
        for (int i = 1; i < TO; i++) begin
            step("to_fetch", 0, 0);
            check("to_irw", 32'(bus.IRWrite), 0);
            check("to_pcw", 32'(bus.PCWrite), 0);
        end
        step("to_fault", 15, 0);
        check("to_fault_flag", 32'(bus.fault), 1);
        do_reset("to_rst");

        // Completion on the last allowed cycle wins
        at("ok_f0", 0, 0);
        for (int i = 1; i < TO - 1; i++) step("ok_fetch", 0, 0);
        step("ok_last", 0, 1);
        check("ok_irw", 32'(bus.IRWrite), 1);
        step("ok_decode", 1, 1);
        step("ok_exec", 6, 1);
        step("ok_aluwb", 8, 1);
        step("ok_fetch2", 0, 1);

        // Reset in the middle of a stalled store
        bus.opcode = OP_SW;
        step("rw_decode", 1, 1);
        step("rw_memadr", 2, 0);
        step("rw_memwr1", 5, 0);
        step("rw_memwr2", 5, 0);
        check("rw_mw_before", 32'(bus.MemWrite), 1);
        reset = 1'b1;
        #1;
        check("rw_mw_after", 32'(bus.MemWrite), 0);
        check("rw_state_after", 32'(bus.state), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.opcode = OP_R;
        at("rw_fetch", 0, 1);
        step("rw_decode2", 1, 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
